// File: rtl/trdb_packet_decoder.sv
// -----------------------------------------------------------------------------
// trdb_packet_decoder
// Receive side of the trace encoder packet path. Rebuilds length-framed packets
// from a byte stream, sign-extends the payload from its highest received bit and
// presents the decoded fields on a valid/ready port.
//
// Optional feature: define TRDB_DEC_STATS_EN to add saturating packet and
// length-error counters (pkt_count_o, err_count_o).
// -----------------------------------------------------------------------------
module trdb_packet_decoder #(
  parameter int ADDR_W      = 32,
  parameter int MAX_PAYLOAD = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_i,
  output logic                     byte_ready_o,
  output logic                     pkt_valid_o,
  input  logic                     pkt_ready_i,
  output logic [1:0]               format_o,
  output logic [1:0]               subformat_o,
  output logic [ADDR_W-1:0]        address_o,
  output logic [4:0]               branches_o,
  output logic [30:0]              branch_map_o,
  output logic [1:0]               priv_o,
  output logic                     branch_o,
  output logic                     notify_o,
  output logic                     updiscon_o,
  output logic [8*MAX_PAYLOAD-1:0] payload_o,
  output logic                     len_err_o
`ifdef TRDB_DEC_STATS_EN
  ,
  output logic [15:0]              pkt_count_o,
  output logic [15:0]              err_count_o
`endif
);

  localparam int BUF_W = 8 * MAX_PAYLOAD;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] data_q,  data_d;
  logic [4:0]       len_q,   len_d;
  logic [4:0]       cnt_q,   cnt_d;
  logic             len_err_q, len_err_d;

  logic             accept;
  logic [4:0]       hdr_len;
  logic             last_byte;

  // Bytes are only taken while no decoded packet is waiting for the sink.
  assign byte_ready_o = (state_q != OUT);
  assign pkt_valid_o  = (state_q == OUT);
  assign accept       = byte_valid_i && byte_ready_o;
  assign hdr_len      = byte_i[4:0];
  assign last_byte    = (cnt_q == len_q - 5'd1);

  // State, length, counter and payload buffer registers.
  // NOTE: the payload buffer is a plain register bank, so it is reset like any
  // other state; a reset mid-packet must leave no stale bytes on payload_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state logic: header parsing, payload capture with sign extension on
  // the last byte, oversized-packet drop and output hand-off.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d = hdr_len;
          cnt_d = '0;
          if (hdr_len == 5'd0) begin
            len_err_d = 1'b1;
          end else if (int'(hdr_len) > MAX_PAYLOAD) begin
            len_err_d = 1'b1;
            state_d   = DROP;
          end else begin
            data_d  = '0;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          // Write the byte into its slot; on the final byte, every slot above it
          // is filled with the byte's MSB so the buffer enters OUT sign-extended.
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (i == int'(cnt_q)) begin
              data_d[8*i +: 8] = byte_i;
            end else if (last_byte && (i > int'(cnt_q))) begin
              data_d[8*i +: 8] = {8{byte_i[7]}};
            end
          end
          cnt_d = cnt_q + 5'd1;
          if (last_byte) begin
            state_d = OUT;
          end
        end
      end

      DROP: begin
        if (accept) begin
          cnt_d = cnt_q + 5'd1;
          if (last_byte) begin
            state_d = IDLE;
          end
        end
      end

      OUT: begin
        if (pkt_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Field extraction from the sign-extended buffer; fields that do not belong
  // to the current format stay at zero.
  always_comb begin
    logic [ADDR_W-2:0] addr_field;

    addr_field   = '0;
    subformat_o  = '0;
    branches_o   = '0;
    branch_map_o = '0;
    priv_o       = '0;
    branch_o     = 1'b0;
    notify_o     = 1'b0;
    updiscon_o   = 1'b0;

    unique case (data_q[1:0])
      2'd1: begin
        branches_o   = data_q[6:2];
        branch_map_o = data_q[37:7];
        addr_field   = data_q[38 +: ADDR_W-1];
      end
      2'd2: begin
        addr_field = data_q[2 +: ADDR_W-1];
        notify_o   = data_q[ADDR_W+1];
        updiscon_o = data_q[ADDR_W+2];
      end
      2'd3: begin
        subformat_o = data_q[3:2];
        branch_o    = data_q[4];
        priv_o      = data_q[6:5];
        addr_field  = data_q[7 +: ADDR_W-1];
      end
      default: ;
    endcase

    address_o = {addr_field, 1'b0};
  end

  assign format_o  = data_q[1:0];
  assign payload_o = data_q;
  assign len_err_o = len_err_q;

`ifdef TRDB_DEC_STATS_EN
  logic [15:0] pkt_count_q;
  logic [15:0] err_count_q;

  // Saturating counters of delivered packets and illegal headers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (pkt_valid_o && pkt_ready_i && (pkt_count_q != 16'hFFFF)) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (len_err_q && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign pkt_count_o = pkt_count_q;
  assign err_count_o = err_count_q;
`endif

endmodule
